// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The master side is the controller. It reads the opcode and the status inputs,
// and it drives every mux select, enable and memory strobe.
interface multicycle_controller_if;

  // Status coming back from the instruction register, memory and ALU
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       BranchTaken;

  // Control driven into the datapath
  logic       PCWrite;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       RegWrite;
  logic [1:0] WBSel;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       PCSrc;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
    input  Opcode, mem_ready, BranchTaken,
    output PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, WBSel,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_instr
  );

  modport slave (
    output Opcode, mem_ready, BranchTaken,
    input  PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, WBSel,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_instr
  );

endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the shared-memory multicycle RV32I datapath.
// Each instruction moves through fetch, decode, execute, memory and write-back
// steps. Every output depends only on the current state. Inside a few states,
// an output is also gated by mem_ready or BranchTaken.
// An unsupported opcode parks the machine in TRAP until reset.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JALR_ADDR,
    S_TRAP
  } state_t;

  state_t state_q, state_d;

  // State register: an asynchronous reset drops the strobes at once and restarts from RESET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs: everything defaults to 0, and each state raises only what it needs
  always_comb begin
    state_d           = state_q;
    bus.PCWrite       = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IorD          = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.WBSel         = 2'b00;
    bus.ALUSrcA       = 2'b00;
    bus.ALUSrcB       = 2'b00;
    bus.ALUOp         = 3'b000;
    bus.PCSrc         = 1'b0;
    bus.instr_done    = 1'b0;
    bus.illegal_instr = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b0;
        bus.ALUSrcA = 2'b00;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 3'b001;
        bus.PCSrc   = 1'b0;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Precompute the PC-relative target (OldPC + imm) into ALUOut for branches and JAL
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 3'b001;
        case (bus.Opcode)
          OP_R, OP_I:    state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BR:         state_d = S_BRANCH;
          OP_JAL:        state_d = S_JUMP;
          OP_JALR:       state_d = S_JALR_ADDR;
          default:       state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        bus.ALUSrcA = 2'b10;
        if (bus.Opcode == OP_I) begin
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = 3'b010;
        end else begin
          bus.ALUSrcB = 2'b00;
          bus.ALUOp   = 3'b000;
        end
        state_d = S_WB_ALU;
      end

      S_WB_ALU: begin
        bus.RegWrite   = 1'b1;
        bus.WBSel      = 2'b00;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_ADDR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 3'b001;
        if (bus.Opcode == OP_LW) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end

      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        bus.RegWrite   = 1'b1;
        bus.WBSel      = 2'b01;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b00;
        bus.ALUOp      = 3'b100;
        bus.PCSrc      = 1'b1;
        bus.PCWrite    = bus.BranchTaken;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_JUMP: begin
        // The link value PC (already PC+4) is written on the same edge that loads the target
        bus.RegWrite   = 1'b1;
        bus.WBSel      = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.PCSrc      = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_JALR_ADDR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 3'b010;
        state_d     = S_JUMP;
      end

      S_TRAP: begin
        bus.illegal_instr = 1'b1;
        state_d           = S_TRAP;
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// The stimulus side drives one cycle of inputs at a time. For each cycle it
// queues the full control vector expected from the state table.
// The monitor pops one entry at every negative edge, and also whenever an
// asynchronous mid-cycle sample is requested.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic clk;
  logic rst_n;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compareCount;
  int mismatchCount;
  logic [17:0] expQ[$];
  string nameQ[$];
  event sampleNow;

  // Free-running clock with a period of 10 time units
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit order: PCWrite IRWrite MemRead MemWrite IorD RegWrite WBSel ALUSrcA ALUSrcB ALUOp PCSrc instr_done illegal_instr
  function automatic logic [17:0] pack(input logic pcw, input logic irw, input logic mr, input logic mw,
                                       input logic iord, input logic rw, input logic [1:0] wb,
                                       input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op,
                                       input logic pcs, input logic done, input logic ill);
    return {pcw, irw, mr, mw, iord, rw, wb, sa, sb, op, pcs, done, ill};
  endfunction

  function automatic logic [17:0] zeroExp();
    return 18'd0;
  endfunction
  function automatic logic [17:0] fetchExp(input logic r);
    return pack(r, r, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] decodeExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b001, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] execRExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] execIExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] wbAluExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [17:0] memAddrExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b001, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] memRdExp();
    return pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] wbMemExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [17:0] memWrExp(input logic r);
    return pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, r, 1'b0);
  endfunction
  function automatic logic [17:0] branchExp(input logic t);
    return pack(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b100, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [17:0] jumpExp();
    return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [17:0] jalrAddrExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] trapExp();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
  endfunction

  // Drive one cycle of inputs just after the rising edge, and queue what the next negative edge should show
  task automatic applyStimulus(input logic rstN, input logic [6:0] op, input logic mr, input logic bt,
                               input logic [17:0] exp, input string name);
    @(posedge clk);
    #1;
    rst_n           = rstN;
    bus.Opcode      = op;
    bus.mem_ready   = mr;
    bus.BranchTaken = bt;
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  // Compare the current control vector against the oldest queued expectation
  task automatic checkOutput();
    logic [17:0] actual;
    logic [17:0] exp;
    string name;
    actual = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.IorD, bus.RegWrite, bus.WBSel,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.instr_done, bus.illegal_instr};
    exp  = expQ.pop_front();
    name = nameQ.pop_front();
    compareCount++;
    if (actual !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, exp);
    end
  endtask

  // Monitor: sample at every falling edge, or on an explicit mid-cycle request
  initial begin
    forever begin
      @(negedge clk or sampleNow);
      if (expQ.size() != 0) checkOutput();
    end
  end

  // Fetch with zero wait states, using a junk opcode to show that FETCH ignores it
  task automatic fetchZeroWait(input string name);
    applyStimulus(1'b1, OP_BAD, 1'b1, 1'b0, fetchExp(1'b1), name);
  endtask

  initial begin
    compareCount    = 0;
    mismatchCount   = 0;
    rst_n           = 1'b0;
    bus.Opcode      = 7'd0;
    bus.mem_ready   = 1'b0;
    bus.BranchTaken = 1'b0;

    // Reset held for three cycles, then released into a fetch with two wait states
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'd0, 1'b1, 1'b1, zeroExp(), "resetHeld");
    applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, zeroExp(), "resetReleaseCycle");
    applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, fetchExp(1'b0), "fetchWait1");
    applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, fetchExp(1'b0), "fetchWait2");
    applyStimulus(1'b1, 7'd0, 1'b1, 1'b0, fetchExp(1'b1), "fetchReady");

    // ADD: 4 cycles, with instr_done in WB_ALU
    applyStimulus(1'b1, OP_R, 1'b1, 1'b0, decodeExp(), "addDecode");
    applyStimulus(1'b1, OP_R, 1'b1, 1'b0, execRExp(), "addExec");
    applyStimulus(1'b1, OP_R, 1'b1, 1'b0, wbAluExp(), "addWb");

    // LW: 5 cycles, with write-back from MDR
    fetchZeroWait("lwFetch");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, decodeExp(), "lwDecode");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, memAddrExp(), "lwMemAddr");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, memRdExp(), "lwMemRd");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, wbMemExp(), "lwWbMem");

    // SW: 4 cycles, with a single MemWrite cycle that also completes
    fetchZeroWait("swFetch");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, decodeExp(), "swDecode");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, memAddrExp(), "swMemAddr");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, memWrExp(1'b1), "swMemWr");

    // I-type, using a junk mem_ready to show that EXEC and WB ignore it
    fetchZeroWait("addiFetch");
    applyStimulus(1'b1, OP_I, 1'b0, 1'b0, decodeExp(), "addiDecode");
    applyStimulus(1'b1, OP_I, 1'b0, 1'b0, execIExp(), "addiExec");
    applyStimulus(1'b1, OP_I, 1'b0, 1'b0, wbAluExp(), "addiWb");

    // LW with two wait states in MEM_RD: the request stays stable
    fetchZeroWait("lwWaitFetch");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, decodeExp(), "lwWaitDecode");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, memAddrExp(), "lwWaitMemAddr");
    applyStimulus(1'b1, OP_LW, 1'b0, 1'b0, memRdExp(), "lwWaitMemRd1");
    applyStimulus(1'b1, OP_LW, 1'b0, 1'b0, memRdExp(), "lwWaitMemRd2");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, memRdExp(), "lwWaitMemRd3");
    applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, wbMemExp(), "lwWaitWbMem");

    // Branch taken, then branch not taken
    fetchZeroWait("brTakenFetch");
    applyStimulus(1'b1, OP_BR, 1'b1, 1'b1, decodeExp(), "brTakenDecode");
    applyStimulus(1'b1, OP_BR, 1'b1, 1'b1, branchExp(1'b1), "brTaken");
    fetchZeroWait("brNotFetch");
    applyStimulus(1'b1, OP_BR, 1'b1, 1'b0, decodeExp(), "brNotDecode");
    applyStimulus(1'b1, OP_BR, 1'b1, 1'b0, branchExp(1'b0), "brNotTaken");

    // JAL, then JALR through JALR_ADDR
    fetchZeroWait("jalFetch");
    applyStimulus(1'b1, OP_JAL, 1'b1, 1'b0, decodeExp(), "jalDecode");
    applyStimulus(1'b1, OP_JAL, 1'b1, 1'b0, jumpExp(), "jalJump");
    fetchZeroWait("jalrFetch");
    applyStimulus(1'b1, OP_JALR, 1'b1, 1'b0, decodeExp(), "jalrDecode");
    applyStimulus(1'b1, OP_JALR, 1'b1, 1'b0, jalrAddrExp(), "jalrAddr");
    applyStimulus(1'b1, OP_JALR, 1'b1, 1'b0, jumpExp(), "jalrJump");

    // SW stalled in MEM_WR, then an asynchronous reset in the middle of a cycle
    fetchZeroWait("swRstFetch");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, decodeExp(), "swRstDecode");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, memAddrExp(), "swRstMemAddr");
    applyStimulus(1'b1, OP_SW, 1'b0, 1'b0, memWrExp(1'b0), "swRstMemWrWait1");
    applyStimulus(1'b1, OP_SW, 1'b0, 1'b0, memWrExp(1'b0), "swRstMemWrWait2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expQ.push_back(zeroExp());
    nameQ.push_back("asyncResetDropsMemWrite");
    -> sampleNow;
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b0, zeroExp(), "asyncResetHeld");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, zeroExp(), "asyncResetRelease");
    applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, fetchExp(1'b1), "asyncResetRestartFetch");

    // Illegal opcode: enters TRAP after DECODE and stays there for 20 cycles
    applyStimulus(1'b1, OP_BAD, 1'b1, 1'b1, decodeExp(), "illegalDecode");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? OP_R : OP_SW, 1'b1, 1'b1, trapExp(), $sformatf("trapHold%0d", i));
    end
    applyStimulus(1'b0, OP_R, 1'b1, 1'b1, zeroExp(), "trapResetClears");
    applyStimulus(1'b1, OP_R, 1'b1, 1'b1, zeroExp(), "trapResetRelease");
    applyStimulus(1'b1, OP_R, 1'b0, 1'b0, fetchExp(1'b0), "trapRestartFetch");

    // Let the monitor drain the last expectation, then confirm nothing is left over
    @(negedge clk);
    #1;
    compareCount++;
    if (expQ.size() != 0) begin
      mismatchCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Moore state machine that sequences the shared-memory multicycle RV32I datapath.
- Decodes the 7-bit opcode latched in the instruction register.
- Walks each instruction through fetch, decode, execute, memory and write-back steps.
- Drives every datapath mux select, register-enable and memory strobe.
- Sits between the instruction register and the datapath, and replaces the single-cycle combinational decoder for the multicycle core.

## Interface

Parameters: none.

- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  7  opcode field from instruction register (valid from DECODE onward)
- mem_ready  in  1  memory handshake: request completes in this cycle
- BranchTaken  in  1  ALU comparison result for the current branch
- PCWrite  out  1  load PC
- IRWrite  out  1  load instruction register and OldPC
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- RegWrite  out  1  register file write enable
- WBSel  out  2  write-back source: 00=ALUOut, 01=MDR, 10=PC (link)
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=constant 4, 10=immediate
- ALUOp  out  3  000=R-type funct decode, 001=add, 010=I-type funct decode, 100=branch compare
- PCSrc  out  1  PC source: 0=ALU result, 1=ALUOut
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_instr  out  1  sticky; set on an unsupported opcode

## Operation

Opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011, JAL=1101111, JALR=1100111.

Every output is a function of the state, gated by mem_ready or BranchTaken only where stated. Any output not listed for a state is 0.

- RESET: all outputs 0. Always goes to FETCH on the next edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=001, PCSrc=0.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=001 (branch/JAL target into ALUOut). Next state by opcode:
  - R, I → EXEC
  - LW, SW → MEM_ADDR
  - BR → BRANCH
  - JAL → JUMP
  - JALR → JALR_ADDR
  - any other → TRAP
- EXEC:
  - R: ALUSrcA=10, ALUSrcB=00, ALUOp=000.
  - I: ALUSrcA=10, ALUSrcB=10, ALUOp=010.
  - Goes to WB_ALU.
- WB_ALU: RegWrite=1, WBSel=00, instr_done=1. Goes to FETCH.
- MEM_ADDR: ALUSrcA=10, ALUSrcB=10, ALUOp=001. LW goes to MEM_RD; SW goes to MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Waits for mem_ready, then goes to WB_MEM.
- WB_MEM: RegWrite=1, WBSel=01, instr_done=1. Goes to FETCH.
- MEM_WR: MemWrite=1, IorD=1, instr_done=mem_ready. Waits for mem_ready, then goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=100, PCSrc=1, PCWrite=BranchTaken, instr_done=1. Goes to FETCH.
- JUMP (JAL): RegWrite=1, WBSel=10, PCWrite=1, PCSrc=1, instr_done=1. Goes to FETCH.
  - The register file captures the pre-update PC (already PC+4) on the same edge that loads the new PC.
- JALR_ADDR: ALUSrcA=10, ALUSrcB=10, ALUOp=010. Goes to JUMP.
- TRAP: illegal_instr=1; all other outputs 0. Stays in TRAP until rst_n is asserted.

## Timing

- Reset:
  - rst_n low forces RESET immediately (asynchronous), regardless of clock. All outputs are 0 and illegal_instr clears.
  - Deassertion is sampled on the next rising edge: the first edge moves RESET→FETCH.
- Reset mid-operation (including while MemWrite=1): strobes drop asynchronously. There is no resume; execution restarts from FETCH.
- Latency, zero-wait memory (mem_ready=1 on the first request cycle):
  - R/I: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BR: 3 cycles
  - JAL: 3 cycles
  - JALR: 4 cycles
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Memory request handshake:
  - MemRead/MemWrite and IorD stay stable for the whole request, until the cycle in which mem_ready=1.
  - mem_ready is ignored in every other state.
- Opcode is read only in DECODE, MEM_ADDR and EXEC. Changes in other states have no effect.
- instr_done is high for exactly one cycle per instruction, never in TRAP, and never twice without an intervening FETCH.

## Test plan

- Reset and wait state: hold rst_n=0 for 3 cycles, then release with mem_ready=0 for 2 cycles → all outputs 0 during reset; FETCH holds MemRead=1 with IRWrite=0 for 2 cycles; IRWrite=PCWrite=1 in the third FETCH cycle.
- Zero-wait instruction sequence: ADD (0110011), then LW, then SW, all with mem_ready=1 → instr_done pulses after 4, 5 and 4 cycles.
  - LW write-back: RegWrite=1 with WBSel=01.
  - SW: MemWrite=1 with IorD=1 for 1 cycle.
- Branch both ways: BR with BranchTaken=1, then with BranchTaken=0 → PCWrite=1 with PCSrc=1 for the taken case; PCWrite stays 0 in BRANCH for the not-taken case. Both take 3 cycles.
- Jumps: JAL, then JALR → JUMP asserts RegWrite=1, WBSel=10, PCWrite=1 and PCSrc=1 in the same cycle. JALR passes through JALR_ADDR with ALUOp=010 and ALUSrcB=10.
- Illegal opcode 1111111 → TRAP after DECODE; illegal_instr=1 stays set with no strobes for 20 cycles. Pulsing rst_n low clears it and restarts FETCH.
- Asynchronous reset during MEM_WR with mem_ready=0 → MemWrite falls in the same cycle as rst_n without waiting for a clock edge; the first state after release is FETCH.
